// File: rtl/stream_bw_pkg.sv
// Shared constants and types for the stream bandwidth generator and the echo block.
package stream_bw_pkg;

  localparam logic [31:0] SIG_HI  = 32'h42424242;
  localparam logic [31:0] SIG_LO  = 32'hDEADBEEF;
  localparam logic [31:0] PAT_XOR = 32'hA5A5A5A5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } bw_state_e;

  // Beat payload for pattern word w at beat index idx.
  function automatic logic [127:0] tx_pattern(input logic [31:0] w, input logic [31:0] idx);
    return {~w, w ^ PAT_XOR, idx, w};
  endfunction

endpackage

// File: rtl/stream_bw_checker.sv
// In-order response checker: tracks the echo block's running sum and counts
// responses that differ from the expected signature/sum/word.
module stream_bw_checker
  import stream_bw_pkg::*;
#(
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             rx_hs_i,
  input  logic [127:0]     rx_data_i,
  input  logic [31:0]      rx_idx_i,
  input  logic [31:0]      seed_i,
  output logic [ERR_W-1:0] err_count_o,
  output logic [31:0]      first_err_idx_o
);

  logic [31:0]      exp_sum_q, exp_sum_d, exp_sum_nx, exp_word;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic [31:0]      first_err_idx_q, first_err_idx_d;
  logic [127:0]     exp_resp;
  logic             mismatch;

  // Saturating increment of the error counter.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == {ERR_W{1'b1}}) ? v : v + ERR_W'(1);
  endfunction

  // Build the expected response for handshake k and decide the next counters.
  always_comb begin
    exp_word        = seed_i + rx_idx_i;
    exp_sum_nx      = exp_sum_q + exp_word;
    exp_resp        = {SIG_HI, SIG_LO, exp_sum_nx, exp_word};
    mismatch        = rx_hs_i && (rx_data_i != exp_resp);
    exp_sum_d       = exp_sum_q;
    err_count_d     = err_count_q;
    first_err_idx_d = first_err_idx_q;
    if (clr_i) begin
      // The running sum mirrors the echo block, which keeps it across runs.
      err_count_d     = '0;
      first_err_idx_d = '0;
    end else if (rx_hs_i) begin
      exp_sum_d = exp_sum_nx;
      if (mismatch) begin
        if (err_count_q == '0) first_err_idx_d = rx_idx_i;
        err_count_d = sat_inc(err_count_q);
      end
    end
  end

  // Checker state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exp_sum_q       <= '0;
      err_count_q     <= '0;
      first_err_idx_q <= '0;
    end else begin
      exp_sum_q       <= exp_sum_d;
      err_count_q     <= err_count_d;
      first_err_idx_q <= first_err_idx_d;
    end
  end

  assign err_count_o     = err_count_q;
  assign first_err_idx_o = first_err_idx_q;

endmodule

// File: rtl/stream_bw_generator.sv
// Loopback traffic generator: drives a numbered beat pattern into the echo
// block, checks its responses in order and aborts a stalled run on timeout.
module stream_bw_generator
  import stream_bw_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024,
  parameter int ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      num_beats,
  input  logic [31:0]      seed,
  input  logic             rx_hold,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [ERR_W-1:0] err_count,
  output logic [31:0]      first_err_idx,
  output logic [31:0]      tx_count,
  output logic [31:0]      rx_count,
  output logic             tx_valid,
  input  logic             tx_rdy,
  output logic [127:0]     tx_data,
  input  logic             rx_valid,
  output logic             rx_rdy,
  input  logic [127:0]     rx_data
);

  bw_state_e   state_q, state_d;
  logic [31:0] num_beats_q, num_beats_d;
  logic [31:0] seed_q, seed_d;
  logic [31:0] tx_count_q, tx_count_d;
  logic [31:0] rx_count_q, rx_count_d;
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic        timeout_q, timeout_d;
  logic        accept, tx_hs, rx_hs;

  assign accept   = (state_q == ST_IDLE) && start;
  assign tx_valid = (state_q == ST_RUN) && (tx_count_q < num_beats_q);
  assign rx_rdy   = (state_q == ST_RUN) && !rx_hold;
  assign tx_hs    = tx_valid && tx_rdy;
  assign rx_hs    = rx_valid && rx_rdy;
  // Gated so the bus reads zero whenever no beat is offered (including reset).
  assign tx_data  = tx_valid ? tx_pattern(seed_q + tx_count_q, tx_count_q) : '0;

  // Run control: FSM, beat/response counters and the no-progress timeout.
  always_comb begin
    state_d     = state_q;
    num_beats_d = num_beats_q;
    seed_d      = seed_q;
    tx_count_d  = tx_count_q;
    rx_count_d  = rx_count_q;
    tmo_cnt_d   = tmo_cnt_q;
    timeout_d   = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_RUN;
          num_beats_d = num_beats;
          seed_d      = seed;
          tx_count_d  = '0;
          rx_count_d  = '0;
          tmo_cnt_d   = '0;
          timeout_d   = 1'b0;
        end
      end
      ST_RUN: begin
        if (tx_hs) tx_count_d = tx_count_q + 32'd1;
        if (rx_hs) begin
          rx_count_d = rx_count_q + 32'd1;
          tmo_cnt_d  = '0;
        end else begin
          tmo_cnt_d  = tmo_cnt_q + 32'd1;
        end
        // Completion is judged on the post-handshake count so DONE follows the last response directly;
        // a handshake always defeats a timeout in the same cycle.
        if (rx_count_d == num_beats_q) begin
          state_d = ST_DONE;
        end else if (!rx_hs && (tmo_cnt_d == 32'(TIMEOUT_CYC))) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and run-parameter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      num_beats_q <= '0;
      seed_q      <= '0;
      tx_count_q  <= '0;
      rx_count_q  <= '0;
      tmo_cnt_q   <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_beats_q <= num_beats_d;
      seed_q      <= seed_d;
      tx_count_q  <= tx_count_d;
      rx_count_q  <= rx_count_d;
      tmo_cnt_q   <= tmo_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  stream_bw_checker #(
    .ERR_W (ERR_W)
  ) u_checker (
    .clk             (clk),
    .rst_n           (rst_n),
    .clr_i           (accept),
    .rx_hs_i         (rx_hs),
    .rx_data_i       (rx_data),
    .rx_idx_i        (rx_count_q),
    .seed_i          (seed_q),
    .err_count_o     (err_count),
    .first_err_idx_o (first_err_idx)
  );

  assign busy     = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign done     = (state_q == ST_DONE);
  assign timeout  = timeout_q;
  assign tx_count = tx_count_q;
  assign rx_count = rx_count_q;

endmodule

// File: tb/tb_stream_bw_generator.sv
// Bench for stream_bw_generator: an echo-block model answers each accepted
// beat; a table of runs is applied, followed by reset and dropped-start sequences.
module tb_stream_bw_generator;
  import stream_bw_pkg::*;

  localparam int          TMO  = 16;
  localparam logic [31:0] NONE = 32'hFFFF_FFFF;

  logic         clk = 1'b0;
  logic         rst_n, start, rx_hold, tx_rdy, rx_valid;
  logic [31:0]  num_beats, seed;
  logic         busy, done, timeout, tx_valid, rx_rdy;
  logic [15:0]  err_count;
  logic [31:0]  first_err_idx, tx_count, rx_count;
  logic [127:0] tx_data, rx_data;

  always #5 clk = ~clk;

  stream_bw_generator #(.TIMEOUT_CYC(TMO), .ERR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_beats(num_beats), .seed(seed),
    .rx_hold(rx_hold), .busy(busy), .done(done), .timeout(timeout),
    .err_count(err_count), .first_err_idx(first_err_idx), .tx_count(tx_count),
    .rx_count(rx_count), .tx_valid(tx_valid), .tx_rdy(tx_rdy), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_rdy(rx_rdy), .rx_data(rx_data)
  );

  typedef struct {
    logic [31:0] seed, nb, flip, limit;
    logic        stall;
    logic [31:0] exp_err, exp_fidx, exp_tx, exp_rx;
    logic        exp_tmo;
    logic [31:0] exp_last_sum;
  } vec_t;

  vec_t         tbl[6];
  vec_t         vpost;
  int           n_vec = 0, n_err = 0;

  // Echo-block model and run bookkeeping.
  logic [127:0] resp_q[$];
  logic [31:0]  echo_sum, seed_m, flip_idx, resp_limit, model_tx, model_rx, echo_cnt, last_sum;
  logic         stall_en, prev_stall, txv_seen, got;
  logic [127:0] prev_data;
  int           cyc = 0, rx_hs_cyc = 0, start_cyc = 0, done_cyc = 0;
  logic [31:0]  sums_rec[4], run0_sums[4], exp_sums[4];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // One clock: drive inputs, check the offered beat, then advance the echo model.
  task automatic cycle();
    logic hs_tx, hs_rx;
    logic [31:0] w;
    logic [127:0] r, cap;
    tx_rdy   = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    rx_hold  = stall_en ? ($urandom_range(0, 3) == 0) : 1'b0;
    rx_valid = (resp_q.size() != 0) && (model_rx < resp_limit);
    rx_data  = rx_valid ? resp_q[0] : '0;
    #1;
    if (tx_valid) begin
      txv_seen = 1'b1;
      w = seed_m + model_tx;
      chk("tx_data", tx_data, {~w, w ^ PAT_XOR, model_tx, w});
    end
    if (prev_stall) begin
      chk("tx_hold_valid", 128'(tx_valid), 128'(1));
      chk("tx_hold_data", tx_data, prev_data);
    end
    prev_stall = tx_valid && !tx_rdy;
    prev_data  = tx_data;
    hs_tx = tx_valid && tx_rdy;
    hs_rx = rx_valid && rx_rdy;
    cap   = tx_data;
    @(posedge clk);
    #1;
    cyc++;
    if (hs_tx) begin
      echo_sum = echo_sum + cap[31:0];
      r = {SIG_HI, SIG_LO, echo_sum, cap[31:0]};
      if (echo_cnt == flip_idx) r[64] = ~r[64];
      resp_q.push_back(r);
      echo_cnt++;
      model_tx++;
    end
    if (hs_rx) begin
      r = resp_q.pop_front();
      if (model_rx < 4) sums_rec[model_rx[1:0]] = r[63:32];
      last_sum = r[63:32];
      model_rx++;
      rx_hs_cyc = cyc;
    end
  endtask

  task automatic begin_run(input vec_t v);
    seed_m = v.seed; flip_idx = v.flip; resp_limit = v.limit; stall_en = v.stall;
    model_tx = 0; model_rx = 0; echo_cnt = 0; txv_seen = 1'b0; prev_stall = 1'b0;
    resp_q.delete();
    seed = v.seed; num_beats = v.nb; start = 1'b1;
    cycle();
    start = 1'b0;
    start_cyc = cyc;
    chk("busy_after_start", 128'(busy), 128'(1));
  endtask

  task automatic do_run(input vec_t v, input string nm);
    begin_run(v);
    got = 1'b0;
    for (int i = 0; i < 20000 && !got; i++) begin
      cycle();
      got = done;
    end
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL %s done_wait: got no done, expected done", nm);
    end else begin
      done_cyc = cyc;
      chk({nm, "_err_count"}, 128'(err_count), 128'(v.exp_err));
      chk({nm, "_first_err_idx"}, 128'(first_err_idx), 128'(v.exp_fidx));
      chk({nm, "_tx_count"}, 128'(tx_count), 128'(v.exp_tx));
      chk({nm, "_rx_count"}, 128'(rx_count), 128'(v.exp_rx));
      chk({nm, "_timeout"}, 128'(timeout), 128'(v.exp_tmo));
      chk({nm, "_busy_in_done"}, 128'(busy), 128'(1));
      if (v.exp_rx != 0) chk({nm, "_last_sum"}, 128'(last_sum), 128'(v.exp_last_sum));
      if (v.exp_tmo) chk({nm, "_tmo_delay"}, 128'(done_cyc - rx_hs_cyc), 128'(TMO));
      if (v.nb == 0) begin
        chk({nm, "_zero_done_delay"}, 128'(done_cyc - start_cyc), 128'(1));
        chk({nm, "_zero_no_txv"}, 128'(txv_seen), 128'(0));
      end
      cycle();
      chk({nm, "_done_pulse"}, 128'(done), 128'(0));
      chk({nm, "_busy_drop"}, 128'(busy), 128'(0));
      chk({nm, "_timeout_sticky"}, 128'(timeout), 128'(v.exp_tmo));
    end
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_busy"}, 128'(busy), 128'(0));
    chk({nm, "_done"}, 128'(done), 128'(0));
    chk({nm, "_timeout"}, 128'(timeout), 128'(0));
    chk({nm, "_tx_valid"}, 128'(tx_valid), 128'(0));
    chk({nm, "_rx_rdy"}, 128'(rx_rdy), 128'(0));
    chk({nm, "_err_count"}, 128'(err_count), 128'(0));
    chk({nm, "_first_err_idx"}, 128'(first_err_idx), 128'(0));
    chk({nm, "_tx_count"}, 128'(tx_count), 128'(0));
    chk({nm, "_rx_count"}, 128'(rx_count), 128'(0));
    chk({nm, "_tx_data"}, tx_data, 128'(0));
  endtask

  initial begin
    //         seed          nb        flip  limit        stall err    fidx   tx        rx        tmo   last sum
    tbl[0] = '{32'h10,       32'd4,    NONE, NONE,        1'b0, 32'd0, 32'd0, 32'd4,    32'd4,    1'b0, 32'h46};
    tbl[1] = '{32'h0,        32'd2,    NONE, NONE,        1'b0, 32'd0, 32'd0, 32'd2,    32'd2,    1'b0, 32'h47};
    tbl[2] = '{32'h100,      32'd5,    32'd2, NONE,       1'b0, 32'd1, 32'd2, 32'd5,    32'd5,    1'b0, 32'h551};
    tbl[3] = '{32'hFFFFFFF0, 32'd1000, NONE, NONE,        1'b1, 32'd0, 32'd0, 32'd1000, 32'd1000, 1'b0, 32'h765FD};
    tbl[4] = '{32'h20,       32'd6,    NONE, 32'd3,       1'b0, 32'd0, 32'd0, 32'd6,    32'd3,    1'b1, 32'h76660};
    tbl[5] = '{32'h77,       32'd0,    NONE, NONE,        1'b0, 32'd0, 32'd0, 32'd0,    32'd0,    1'b0, 32'h0};
    exp_sums[0] = 32'h10; exp_sums[1] = 32'h21; exp_sums[2] = 32'h33; exp_sums[3] = 32'h46;

    rst_n = 1'b0; start = 1'b0; num_beats = '0; seed = '0; rx_hold = 1'b0;
    tx_rdy = 1'b1; rx_valid = 1'b0; rx_data = '0;
    echo_sum = '0; seed_m = '0; flip_idx = NONE; resp_limit = '0; stall_en = 1'b0;
    model_tx = '0; model_rx = '0; echo_cnt = '0; last_sum = '0;
    prev_stall = 1'b0; prev_data = '0; txv_seen = 1'b0; got = 1'b0;
    for (int i = 0; i < 4; i++) sums_rec[i] = '0;
    cycle();
    cycle();
    check_zero("reset");
    rst_n = 1'b1;
    cycle();

    for (int i = 0; i < 6; i++) begin
      do_run(tbl[i], $sformatf("run%0d", i));
      if (i == 0) run0_sums = sums_rec;
    end
    for (int i = 0; i < 4; i++) chk($sformatf("run0_sum%0d", i), 128'(run0_sums[i]), 128'(exp_sums[i]));

    // Start during RUN is dropped, then reset lands mid-run.
    vpost = '{32'h5, 32'd10, NONE, NONE, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0};
    begin_run(vpost);
    cycle();
    cycle();
    seed = 32'h999; num_beats = 32'd1; start = 1'b1;
    cycle();
    start = 1'b0;
    chk("drop_start_tx_count", 128'(tx_count), 128'(model_tx));
    chk("drop_start_busy", 128'(busy), 128'(1));
    cycle();
    rst_n = 1'b0;
    cycle();
    check_zero("midrun_reset");
    rst_n = 1'b1;
    resp_q.delete();
    echo_sum = '0;
    cycle();
    check_zero("after_reset_idle");

    // Running sum restarts from zero after reset.
    vpost = '{32'h1, 32'd2, NONE, NONE, 1'b0, 32'd0, 32'd0, 32'd2, 32'd2, 1'b0, 32'h3};
    do_run(vpost, "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
